// File: rtl/count_stream_checker.sv
// count_stream_checker
//
// Receive-side companion to a free-running up-counter. It samples one count
// word per in_valid cycle and locks onto the +1 sequence (modulo 2^WIDTH).
// Once locked, any word that is not the expected successor is flagged with a
// one-cycle err_pulse. It is also counted in a saturating counter and captured
// in last_bad. The checker then drops back to ACQUIRE to re-establish lock.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   in_data carries a sample this cycle
//   in_data    observed count word
//   clear      synchronous clear of err_count and last_bad
//   locked     high while the state is LOCKED
//   err_pulse  one-cycle pulse per sequence break detected while LOCKED
//   err_count  saturating count of breaks
//   last_bad   in_data value of the most recent break
//   expected   next value the checker expects
//   state      0=UNSYNC, 1=ACQUIRE, 2=LOCKED
//
// All outputs are registered. A decision about the word sampled at a clock
// edge becomes visible right after that edge.

module count_stream_checker #(
    parameter int WIDTH      = 8,
    parameter int LOCK_COUNT = 4,   // legal range 2..15 (run_len is 4 bits)
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [WIDTH-1:0] last_bad,
    output logic [WIDTH-1:0] expected,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        UNSYNC  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam logic [3:0]       LOCK_LEN = 4'(LOCK_COUNT);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] expected_reg, expected_next;
    logic [3:0]       run_len_reg, run_len_next;
    logic             locked_reg, locked_next;
    logic             err_pulse_reg, err_pulse_next;
    logic [ERR_W-1:0] err_count_reg, err_count_next;
    logic [WIDTH-1:0] last_bad_reg, last_bad_next;

    logic             match;
    logic [WIDTH-1:0] seed_next;
    logic [3:0]       run_plus;

    // The +1 additions wrap naturally at WIDTH bits. This makes
    // 2^WIDTH-1 -> 0 a match.
    assign match     = (in_data == expected_reg);
    assign seed_next = in_data + ONE;
    assign run_plus  = run_len_reg + 4'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= UNSYNC;
            expected_reg  <= '0;
            run_len_reg   <= '0;
            locked_reg    <= 1'b0;
            err_pulse_reg <= 1'b0;
            err_count_reg <= '0;
            last_bad_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            expected_reg  <= expected_next;
            run_len_reg   <= run_len_next;
            locked_reg    <= locked_next;
            err_pulse_reg <= err_pulse_next;
            err_count_reg <= err_count_next;
            last_bad_reg  <= last_bad_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        expected_next  = expected_reg;
        run_len_next   = run_len_reg;
        locked_next    = locked_reg;
        err_pulse_next = 1'b0;
        err_count_next = err_count_reg;
        last_bad_next  = last_bad_reg;

        case (state_reg)
            UNSYNC: begin
                if (in_valid) begin
                    // The first sample seeds the sequence and counts as word 1 of the run.
                    expected_next = seed_next;
                    run_len_next  = 4'd1;
                    state_next    = ACQUIRE;
                end
            end
            ACQUIRE: begin
                if (in_valid) begin
                    if (match) begin
                        expected_next = expected_reg + ONE;
                        run_len_next  = run_plus;
                        if (run_plus == LOCK_LEN) begin
                            state_next  = LOCKED;
                            locked_next = 1'b1;
                        end
                    end else begin
                        // Not locked yet, so a break only restarts the run.
                        expected_next = seed_next;
                        run_len_next  = 4'd1;
                    end
                end
            end
            LOCKED: begin
                if (in_valid) begin
                    if (match) begin
                        expected_next = expected_reg + ONE;
                    end else begin
                        err_pulse_next = 1'b1;
                        if (err_count_reg != ERR_MAX) begin
                            err_count_next = err_count_reg + 1'b1;
                        end
                        last_bad_next = in_data;
                        expected_next = seed_next;
                        run_len_next  = 4'd1;
                        state_next    = ACQUIRE;
                        locked_next   = 1'b0;
                    end
                end
            end
            default: begin
                // The encoding 3 is unused. If the state register is ever
                // corrupted into it, recover to UNSYNC.
                state_next  = UNSYNC;
                locked_next = 1'b0;
            end
        endcase

        // clear takes priority over a simultaneous break for the error bookkeeping.
        if (clear) begin
            err_count_next = '0;
            last_bad_next  = '0;
        end
    end

    assign locked    = locked_reg;
    assign err_pulse = err_pulse_reg;
    assign err_count = err_count_reg;
    assign last_bad  = last_bad_reg;
    assign expected  = expected_reg;
    assign state     = state_reg;

endmodule

// File: tb/tb_count_stream_checker.sv
// Testbench for count_stream_checker (WIDTH=8, LOCK_COUNT=4, ERR_W=2).
// The reference model tracks the last accepted word and the length of the
// current +1 run. Expected, state and lock are derived from those two values.

module tb_count_stream_checker;

    localparam int WIDTH      = 8;
    localparam int LOCK_COUNT = 4;
    localparam int ERR_W      = 2;
    localparam int MODV       = 1 << WIDTH;
    localparam int ERR_SAT    = (1 << ERR_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             clear = 1'b0;
    logic             locked;
    logic             err_pulse;
    logic [ERR_W-1:0] err_count;
    logic [WIDTH-1:0] last_bad;
    logic [WIDTH-1:0] expected;
    logic [1:0]       state;

    int tests = 0;
    int fails = 0;

    count_stream_checker #(
        .WIDTH(WIDTH), .LOCK_COUNT(LOCK_COUNT), .ERR_W(ERR_W)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .clear(clear), .locked(locked), .err_pulse(err_pulse),
        .err_count(err_count), .last_bad(last_bad), .expected(expected),
        .state(state)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit m_synced;
    int m_last;     // last valid word seen
    int m_run;      // length of current consecutive +1 run (unbounded)
    int m_errs;
    int m_bad;
    bit m_pulse;

    task automatic model_reset();
        m_synced = 0; m_last = 0; m_run = 0;
        m_errs = 0; m_bad = 0; m_pulse = 0;
    endtask

    function automatic int m_expected();
        return m_synced ? (m_last + 1) % MODV : 0;
    endfunction

    function automatic int m_locked();
        return (m_synced && m_run >= LOCK_COUNT) ? 1 : 0;
    endfunction

    function automatic int m_state();
        if (!m_synced) return 0;
        return (m_run >= LOCK_COUNT) ? 2 : 1;
    endfunction

    task automatic model_step(input bit v, input int d, input bit c);
        m_pulse = 0;
        if (v) begin
            if (!m_synced) begin
                m_synced = 1;
                m_run = 1;
            end else if (d == (m_last + 1) % MODV) begin
                m_run++;
            end else begin
                if (m_run >= LOCK_COUNT) begin
                    m_pulse = 1;
                    m_errs = (m_errs < ERR_SAT) ? m_errs + 1 : ERR_SAT;
                    m_bad = d;
                end
                m_run = 1;
            end
            m_last = d;
        end
        if (c) begin
            m_errs = 0;
            m_bad = 0;
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("state", state, m_state());
        chk("locked", locked, m_locked());
        chk("err_pulse", err_pulse, m_pulse);
        chk("err_count", err_count, m_errs);
        chk("last_bad", last_bad, m_bad);
        chk("expected", expected, m_expected());
    endtask

    // Drive one cycle. Inputs change 1 ns after an edge. Outputs are sampled 1 ns after the next edge.
    task automatic apply(input bit v, input int d, input bit c);
        in_valid = v;
        in_data  = WIDTH'(d);
        clear    = c;
        @(posedge clk);
        model_step(v, d, c);
        #1;
        $display("[TB] v=%0d d=%0d clr=%0d -> state=%0d locked=%0d pulse=%0d err=%0d bad=%0d exp=%0d",
                 v, d, c, state, locked, err_pulse, err_count, last_bad, expected);
        check_model();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        clear = 1'b0;
        #1;
        model_reset();
        @(posedge clk);
        #3;
        rst = 1'b0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit v; int d; bit c;
        int st; int lk; int pu; int ec; int lb; int ex;
    } vec_t;
    vec_t vecs[$];

    task automatic add_vec(input bit v, input int d, input bit c, input int st,
                           input int lk, input int pu, input int ec, input int lb, input int ex);
        vec_t t;
        t.v = v; t.d = d; t.c = c; t.st = st; t.lk = lk;
        t.pu = pu; t.ec = ec; t.lb = lb; t.ex = ex;
        vecs.push_back(t);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        int r;
        int d;
        model_reset();

        // Reset state, observed before any clock edge
        #3;
        chk("reset state", state, 0);
        chk("reset locked", locked, 0);
        chk("reset err_pulse", err_pulse, 0);
        chk("reset err_count", err_count, 0);
        chk("reset last_bad", last_bad, 0);
        chk("reset expected", expected, 0);
        #9;
        rst = 1'b0;

        //       v  d   c  st lk pu ec lb  ex
        add_vec(1, 0,  0, 1, 0, 0, 0, 0,  1);
        add_vec(1, 1,  0, 1, 0, 0, 0, 0,  2);
        add_vec(1, 2,  0, 1, 0, 0, 0, 0,  3);
        add_vec(1, 3,  0, 2, 1, 0, 0, 0,  4);   // lock after 4th word
        add_vec(0, 77, 0, 2, 1, 0, 0, 0,  4);   // idle cycle ignores data
        add_vec(1, 4,  0, 2, 1, 0, 0, 0,  5);
        add_vec(1, 5,  0, 2, 1, 0, 0, 0,  6);
        add_vec(1, 5,  0, 1, 0, 1, 1, 5,  6);   // repeat is a break
        add_vec(1, 6,  0, 1, 0, 0, 1, 5,  7);
        add_vec(0, 0,  1, 1, 0, 0, 0, 0,  7);   // clear while idle
        add_vec(1, 7,  0, 1, 0, 0, 0, 0,  8);
        add_vec(1, 8,  0, 2, 1, 0, 0, 0,  9);   // relock: 5,6,7,8
        add_vec(1, 9,  0, 2, 1, 0, 0, 0, 10);
        add_vec(1, 10, 0, 2, 1, 0, 0, 0, 11);
        add_vec(1, 11, 0, 2, 1, 0, 0, 0, 12);
        add_vec(1, 40, 0, 1, 0, 1, 1, 40, 41);  // break at 40
        add_vec(1, 41, 0, 1, 0, 0, 1, 40, 42);
        add_vec(1, 42, 0, 1, 0, 0, 1, 40, 43);
        add_vec(1, 43, 0, 2, 1, 0, 1, 40, 44);  // relock 4 words from 40
        add_vec(1, 99, 0, 1, 0, 1, 2, 99, 100);
        add_vec(1, 7,  0, 1, 0, 0, 2, 99, 8);   // ACQUIRE mismatch: no error

        foreach (vecs[i]) begin
            apply(vecs[i].v, vecs[i].d, vecs[i].c);
            chk("vec state", state, vecs[i].st);
            chk("vec locked", locked, vecs[i].lk);
            chk("vec err_pulse", err_pulse, vecs[i].pu);
            chk("vec err_count", err_count, vecs[i].ec);
            chk("vec last_bad", last_bad, vecs[i].lb);
            chk("vec expected", expected, vecs[i].ex);
        end

        // Wrap-around while locked
        do_reset();
        for (int k = 249; k <= 252; k++) apply(1, k, 0);
        chk("wrap locked at 252", locked, 1);
        for (int k = 253; k <= 257; k++) begin
            apply(1, k % MODV, 0);
            chk("wrap locked", locked, 1);
            chk("wrap no pulse", err_pulse, 0);
        end
        chk("wrap expected", expected, 2);

        // Gaps: resume at the expected value, then resume one beyond it
        for (int k = 0; k < 5; k++) apply(0, 0, 0);
        apply(1, 2, 0);
        chk("gap resume pulse", err_pulse, 0);
        chk("gap resume locked", locked, 1);
        for (int k = 0; k < 5; k++) apply(0, 0, 0);
        apply(1, 4, 0);
        chk("gap skip pulse", err_pulse, 1);
        chk("gap skip err_count", err_count, 1);
        chk("gap skip state", state, 1);

        // Saturation with ERR_W=2: five breaks in LOCKED
        do_reset();
        for (int k = 0; k < 4; k++) apply(1, k, 0);
        pulses = 0;
        for (int b = 0; b < 5; b++) begin
            apply(1, 100 + 10 * b, 0);
            pulses += err_pulse;
            for (int k = 1; k < 4; k++) begin
                apply(1, 100 + 10 * b + k, 0);
                pulses += err_pulse;
            end
        end
        chk("sat pulse count", pulses, 5);
        chk("sat err_count", err_count, 3);
        chk("sat last_bad", last_bad, 140);
        apply(1, 200, 1);   // 6th break together with clear
        chk("clr+break err_count", err_count, 0);
        chk("clr+break last_bad", last_bad, 0);
        chk("clr+break pulse", err_pulse, 1);
        chk("clr+break state", state, 1);

        // Async reset mid-LOCKED
        for (int k = 201; k <= 203; k++) apply(1, k, 0);
        apply(1, 50, 0);
        for (int k = 51; k <= 53; k++) apply(1, k, 0);
        chk("pre-rst locked", locked, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async rst state", state, 0);
        chk("async rst locked", locked, 0);
        chk("async rst err_count", err_count, 0);
        chk("async rst last_bad", last_bad, 0);
        chk("async rst expected", expected, 0);
        model_reset();
        @(posedge clk);
        #3;
        rst = 1'b0;
        for (int k = 7; k <= 9; k++) apply(1, k, 0);
        chk("post-rst not yet locked", locked, 0);
        apply(1, 10, 0);
        chk("post-rst relock", state, 2);

        // Randomised traffic against the model
        do_reset();
        for (int n = 0; n < 600; n++) begin
            r = int'($urandom_range(99, 0));
            if (r < 70)      d = m_expected();
            else if (r < 78) d = m_last;
            else if (r < 85) d = (m_expected() + 1) % MODV;
            else             d = int'($urandom_range(MODV - 1, 0));
            apply($urandom_range(3, 0) != 0, d, $urandom_range(19, 0) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/count_stream_checker.md
Name: count_stream_checker

Overview:
- Receive-side companion to the free-running up-counter.
- Samples an incoming WIDTH-bit count stream, one word per in_valid cycle, and acquires lock onto the +1 sequence.
- Flags, counts and captures sequence breaks.
- Placed where the counter output is consumed, e.g. a loopback from uo_out to the uio_in/ui_in pins, to prove counter integrity on silicon.

Parameters:
- WIDTH, 8, width of the count word; arithmetic is modulo 2^WIDTH.
- LOCK_COUNT, 4, consecutive in-sequence words, including the seed word, needed to declare lock. Legal range 2..15.
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data is a sample this cycle.
- in_data  input  WIDTH  observed count word.
- clear  input  1  synchronous clear of err_count and last_bad.
- locked  output  1  high while the state is LOCKED.
- err_pulse  output  1  one-cycle pulse per sequence break detected while LOCKED.
- err_count  output  ERR_W  saturating count of breaks.
- last_bad  output  WIDTH  in_data value of the most recent break.
- expected  output  WIDTH  next value the checker expects.
- state  output  2  0=UNSYNC, 1=ACQUIRE, 2=LOCKED; 3 is unused.

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high. Every register is clocked on the rising edge of clk.
- Reset values:
  - state=UNSYNC, expected=0, run_len=0.
  - locked=0, err_pulse=0, err_count=0, last_bad=0.
- Outputs and latency: all outputs are registered. A decision on the word sampled at edge N appears after edge N, i.e. 1-cycle latency.
- Internal run counter: run_len, 4 bits.
- Cycles with in_valid=0 change nothing except the clear effects; gaps of any length are allowed.
- UNSYNC, in_valid=1:
  - expected <= in_data+1 (mod 2^WIDTH); run_len <= 1; state <= ACQUIRE.
- ACQUIRE, in_valid=1, in_data==expected:
  - expected <= expected+1; run_len <= run_len+1.
  - If run_len+1 == LOCK_COUNT: state <= LOCKED, locked <= 1.
- ACQUIRE, in_valid=1, mismatch:
  - Reseed: expected <= in_data+1; run_len <= 1; stay in ACQUIRE.
  - No error is counted and err_pulse stays low.
- LOCKED, in_valid=1, match: expected <= expected+1.
- LOCKED, in_valid=1, mismatch:
  - err_pulse <= 1 for exactly one cycle.
  - err_count <= err_count+1, saturating at 2^ERR_W-1.
  - last_bad <= in_data.
  - Reseed: expected <= in_data+1; run_len <= 1; state <= ACQUIRE; locked <= 0.
- err_pulse is 0 in every cycle not described above.
- Wrap-around: 2^WIDTH-1 followed by 0 is a match, both in ACQUIRE and in LOCKED.
- clear=1 in any state: err_count <= 0 and last_bad <= 0. state, expected and lock are unaffected.
- clear and a break in the same cycle: clear wins for err_count and last_bad (both 0). err_pulse still asserts and the state still drops to ACQUIRE.
- Saturation: at max, err_count holds its value; err_pulse and last_bad still update.
- rst asserted mid-stream: all registers return to reset values immediately, asynchronously. After release, reacquisition starts from UNSYNC and needs LOCK_COUNT words.
- Repeated values: a repeat (same value twice) is a mismatch.

Test Plan:
- Reset, then feed 0,1,2,3 with in_valid=1 every cycle:
  - state goes 1,1,1,2; locked rises after the 4th edge.
  - expected=4; err_count=0.
- Locked at 252, feed 253,254,255,0,1: locked stays 1, err_pulse never asserts, expected=2.
- Locked with expected=10, feed 10,11,40,41,42,43:
  - One err_pulse, the cycle after 40 is sampled; last_bad=40; err_count=1.
  - State goes to ACQUIRE, and relocks after 43 (4 words from 40).
- Locked, drop in_valid for 5 cycles, then resume at the expected value: no error and still locked. Resume instead at expected+1: err_pulse, err_count+1.
- ERR_W=2: force 5 breaks in LOCKED:
  - err_count saturates at 3 and err_pulse fires 5 times.
  - clear asserted together with the 6th break: err_count=0, last_bad=0, err_pulse=1.
- Assert rst for one cycle mid-LOCKED, asynchronous to clk: all outputs zero with no clock edge needed; afterwards LOCK_COUNT valid words relock.
